// File: rtl/gsm_param_if.sv
// rtl/gsm_param_if.sv - command handshake bundle between the game logic and the game-state manager
interface gsm_param_if;
  logic       cmd_valid;
  logic [2:0] cmd;
  logic       cmd_ready;
  logic       cmd_ack;
  logic       cmd_err;

  modport master (
    output cmd_valid,
    output cmd,
    input  cmd_ready,
    input  cmd_ack,
    input  cmd_err
  );

  modport slave (
    input  cmd_valid,
    input  cmd,
    output cmd_ready,
    output cmd_ack,
    output cmd_err
  );
endinterface

// File: rtl/gsm_param.sv
// rtl/gsm_param.sv - parametrised mole-game state manager: state, stage, lives, score, countdown timer
module gsm_param #(
  parameter int CLK_PER_MS   = 1000,
  parameter int MS_PER_SEC   = 1000,
  parameter int NUM_STAGES   = 3,
  parameter int MAX_LIVES    = 3,
  parameter int SCORE_W      = 10,
  parameter int SCORE_STEP   = 10,
  parameter int TIMER_W      = 7,
  parameter int READY_SEC    = 5,
  parameter int PLAY_SEC     = 60,
  parameter int STAGE_DEC    = 10,
  parameter int MIN_PLAY_SEC = 20
) (
  input  logic                              clk_1mhz,
  input  logic                              rst_n,
  gsm_param_if.slave                        cmd_if,
  output logic                              sec_tick,
  output logic                              timer_running,
  output logic [TIMER_W-1:0]                timer,
  output logic [2:0]                        state,
  output logic [$clog2(NUM_STAGES+1)-1:0]   stage,
  output logic [3:0]                        lives,
  output logic [SCORE_W-1:0]                score,
  output logic [SCORE_W-1:0]                hi_score
);

  localparam int STAGE_W = $clog2(NUM_STAGES + 1);
  localparam int MS_W    = $clog2(CLK_PER_MS + 1);
  localparam int SEC_W   = $clog2(MS_PER_SEC + 1);

  localparam logic [MS_W-1:0]    MS_LAST    = MS_W'(CLK_PER_MS - 1);
  localparam logic [SEC_W-1:0]   SEC_LAST   = SEC_W'(MS_PER_SEC - 1);
  localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(NUM_STAGES);
  localparam logic [STAGE_W-1:0] FIRST_STG  = STAGE_W'(1);
  localparam logic [3:0]         FULL_LIVES = 4'(MAX_LIVES);
  localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;
  localparam logic [TIMER_W-1:0] READY_LEN  = TIMER_W'(READY_SEC);

  localparam logic [2:0] CMD_ADD_SCORE  = 3'd0;
  localparam logic [2:0] CMD_LOSE_LIFE  = 3'd1;
  localparam logic [2:0] CMD_PAUSE      = 3'd2;
  localparam logic [2:0] CMD_RESUME     = 3'd3;
  localparam logic [2:0] CMD_ARM        = 3'd4;
  localparam logic [2:0] CMD_NEXT_STAGE = 3'd5;
  localparam logic [2:0] CMD_RESTART    = 3'd6;

  typedef enum logic [2:0] {
    ST_READY     = 3'd0,
    ST_PLAY      = 3'd1,
    ST_PAUSE     = 3'd2,
    ST_OVER      = 3'd3,
    ST_STAGE_CLR = 3'd4,
    ST_GAME_CLR  = 3'd5
  } state_e;

  state_e             state_q, state_d;
  logic [STAGE_W-1:0] stage_q, stage_d;
  logic [3:0]         lives_q, lives_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [SCORE_W-1:0] hi_q, hi_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               running_q, running_d;
  logic [MS_W-1:0]    ms_q, ms_d;
  logic [SEC_W-1:0]   sec_q, sec_d;
  logic               ack_q, ack_d;
  logic               err_q, err_d;
  logic               tick_q, tick_d;
  logic               legal;

  logic               sec_wrap;
  logic               expiry;
  logic [SCORE_W:0]   score_sum;
  logic [SCORE_W-1:0] score_sat;
  logic [SCORE_W-1:0] hi_best;

  // Floor is checked before subtracting so late stages never underflow.
  function automatic logic [TIMER_W-1:0] play_len(input logic [STAGE_W-1:0] s);
    int dec;
    dec = (int'(s) - 1) * STAGE_DEC;
    if (dec + MIN_PLAY_SEC >= PLAY_SEC) return TIMER_W'(MIN_PLAY_SEC);
    return TIMER_W'(PLAY_SEC - dec);
  endfunction

  assign sec_wrap  = running_q && (ms_q == MS_LAST) && (sec_q == SEC_LAST);
  assign expiry    = sec_wrap && (timer_q <= TIMER_W'(1));
  assign score_sum = {1'b0, score_q} + (SCORE_W + 1)'(SCORE_STEP);
  assign score_sat = score_sum[SCORE_W] ? SCORE_MAX : score_sum[SCORE_W-1:0];
  assign hi_best   = (score_q > hi_q) ? score_q : hi_q;

  // The expiry wrap owns the cycle; any offered command waits one cycle.
  assign cmd_if.cmd_ready = !expiry;

  always_comb begin
    state_d   = state_q;
    stage_d   = stage_q;
    lives_d   = lives_q;
    score_d   = score_q;
    hi_d      = hi_q;
    timer_d   = timer_q;
    running_d = running_q;
    ms_d      = ms_q;
    sec_d     = sec_q;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    tick_d    = 1'b0;
    legal     = 1'b0;

    if (running_q) begin
      if (ms_q == MS_LAST) begin
        ms_d  = '0;
        sec_d = (sec_q == SEC_LAST) ? '0 : sec_q + SEC_W'(1);
      end else begin
        ms_d = ms_q + MS_W'(1);
      end
    end

    if (sec_wrap) begin
      tick_d = 1'b1;
      if (timer_q != '0) timer_d = timer_q - TIMER_W'(1);
    end

    if (expiry) begin
      case (state_q)
        ST_READY: begin
          state_d = ST_PLAY;
          timer_d = play_len(stage_q);
          ms_d    = '0;
          sec_d   = '0;
        end
        ST_PLAY: begin
          running_d = 1'b0;
          if (stage_q < LAST_STAGE) begin
            state_d = ST_STAGE_CLR;
          end else begin
            state_d = ST_GAME_CLR;
            hi_d    = hi_best;
          end
        end
        default: ;
      endcase
    end else if (cmd_if.cmd_valid) begin
      case (cmd_if.cmd)
        CMD_ADD_SCORE: if (state_q == ST_PLAY) begin
          legal   = 1'b1;
          score_d = score_sat;
        end
        CMD_LOSE_LIFE: if (state_q == ST_PLAY) begin
          legal = 1'b1;
          if (lives_q != 4'd0) lives_d = lives_q - 4'd1;
          if (lives_q <= 4'd1) begin
            state_d   = ST_OVER;
            running_d = 1'b0;
            hi_d      = hi_best;
          end
        end
        CMD_PAUSE: if (state_q == ST_PLAY) begin
          legal     = 1'b1;
          state_d   = ST_PAUSE;
          running_d = 1'b0;
        end
        CMD_RESUME: if (state_q == ST_PAUSE) begin
          legal     = 1'b1;
          state_d   = ST_PLAY;
          running_d = 1'b1;
        end
        CMD_ARM: if (state_q == ST_READY && !running_q) begin
          legal     = 1'b1;
          timer_d   = READY_LEN;
          running_d = 1'b1;
          ms_d      = '0;
          sec_d     = '0;
        end
        CMD_NEXT_STAGE: if (state_q == ST_STAGE_CLR) begin
          legal     = 1'b1;
          state_d   = ST_READY;
          if (stage_q < LAST_STAGE) stage_d = stage_q + STAGE_W'(1);
          timer_d   = '0;
          running_d = 1'b0;
          ms_d      = '0;
          sec_d     = '0;
        end
        CMD_RESTART: if (state_q == ST_OVER || state_q == ST_GAME_CLR || state_q == ST_READY) begin
          legal     = 1'b1;
          state_d   = ST_READY;
          stage_d   = FIRST_STG;
          lives_d   = FULL_LIVES;
          score_d   = '0;
          timer_d   = '0;
          running_d = 1'b0;
          ms_d      = '0;
          sec_d     = '0;
        end
        default: ;
      endcase
      ack_d = legal;
      err_d = !legal;
    end
  end

  always_ff @(posedge clk_1mhz) begin
    if (!rst_n) begin
      state_q   <= ST_READY;
      stage_q   <= FIRST_STG;
      lives_q   <= FULL_LIVES;
      score_q   <= '0;
      hi_q      <= '0;
      timer_q   <= '0;
      running_q <= 1'b0;
      ms_q      <= '0;
      sec_q     <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      stage_q   <= stage_d;
      lives_q   <= lives_d;
      score_q   <= score_d;
      hi_q      <= hi_d;
      timer_q   <= timer_d;
      running_q <= running_d;
      ms_q      <= ms_d;
      sec_q     <= sec_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      tick_q    <= tick_d;
    end
  end

  assign cmd_if.cmd_ack = ack_q;
  assign cmd_if.cmd_err = err_q;
  assign sec_tick       = tick_q;
  assign timer_running  = running_q;
  assign timer          = timer_q;
  assign state          = state_q;
  assign stage          = stage_q;
  assign lives          = lives_q;
  assign score          = score_q;
  assign hi_score       = hi_q;

endmodule

// File: tb/tb_gsm_param.sv
// tb/tb_gsm_param.sv - directed and random checks of gsm_param against a behavioural game model
module tb_gsm_param;

  localparam int SEC_CYC = 4 * 5;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sec_tick;
  logic       timer_running;
  logic [6:0] timer;
  logic [2:0] state;
  logic [1:0] stage;
  logic [3:0] lives;
  logic [9:0] score;
  logic [9:0] hi_score;

  gsm_param_if cmd_if ();

  gsm_param #(
    .CLK_PER_MS(4), .MS_PER_SEC(5), .NUM_STAGES(2), .MAX_LIVES(3), .SCORE_W(10),
    .SCORE_STEP(10), .TIMER_W(7), .READY_SEC(2), .PLAY_SEC(6), .STAGE_DEC(4), .MIN_PLAY_SEC(3)
  ) dut (
    .clk_1mhz(clk), .rst_n(rst_n), .cmd_if(cmd_if), .sec_tick(sec_tick),
    .timer_running(timer_running), .timer(timer), .state(state), .stage(stage),
    .lives(lives), .score(score), .hi_score(hi_score)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  int m_state, m_stage, m_lives, m_score, m_hi, m_timer, m_elapsed;
  bit m_run, m_tick, m_ack, m_err;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int plen(input int s);
    int v;
    v = 6 - (s - 1) * 4;
    return (v < 3) ? 3 : v;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // One clock edge of the game rules, using a single elapsed-in-second counter.
  task automatic model_step(input bit rn, input bit valid, input int c);
    bit wrap, expire, ok;
    m_ack = 0; m_err = 0; m_tick = 0;
    if (!rn) begin
      m_state = 0; m_stage = 1; m_lives = 3; m_score = 0; m_hi = 0;
      m_timer = 0; m_run = 0; m_elapsed = 0;
      return;
    end
    wrap   = m_run && (m_elapsed == SEC_CYC - 1);
    expire = wrap && (m_timer <= 1);
    if (m_run) m_elapsed = (m_elapsed + 1) % SEC_CYC;
    if (wrap) begin
      m_tick = 1;
      if (m_timer > 0) m_timer--;
    end
    if (expire) begin
      if (m_state == 0) begin
        m_state = 1; m_timer = plen(m_stage); m_elapsed = 0;
      end else if (m_state == 1) begin
        m_run = 0;
        if (m_stage < 2) m_state = 4;
        else begin m_state = 5; m_hi = imax(m_hi, m_score); end
      end
    end else if (valid) begin
      ok = 0;
      case (c)
        0: if (m_state == 1) begin ok = 1; m_score = (m_score + 10 > 1023) ? 1023 : m_score + 10; end
        1: if (m_state == 1) begin
          ok = 1; m_lives--;
          if (m_lives == 0) begin m_state = 3; m_run = 0; m_hi = imax(m_hi, m_score); end
        end
        2: if (m_state == 1) begin ok = 1; m_state = 2; m_run = 0; end
        3: if (m_state == 2) begin ok = 1; m_state = 1; m_run = 1; end
        4: if (m_state == 0 && !m_run) begin ok = 1; m_timer = 2; m_run = 1; m_elapsed = 0; end
        5: if (m_state == 4) begin
          ok = 1; m_state = 0; m_stage = (m_stage < 2) ? m_stage + 1 : 2;
          m_timer = 0; m_run = 0; m_elapsed = 0;
        end
        6: if (m_state == 3 || m_state == 5 || m_state == 0) begin
          ok = 1; m_state = 0; m_stage = 1; m_lives = 3; m_score = 0;
          m_timer = 0; m_run = 0; m_elapsed = 0;
        end
        default: ;
      endcase
      m_ack = ok;
      m_err = !ok;
    end
  endtask

  task automatic cycle();
    bit rn, v;
    int c;
    @(posedge clk);
    rn = rst_n; v = cmd_if.cmd_valid; c = int'(cmd_if.cmd);
    model_step(rn, v, c);
    #1;
    check_eq("state", int'(state), m_state);
    check_eq("stage", int'(stage), m_stage);
    check_eq("lives", int'(lives), m_lives);
    check_eq("score", int'(score), m_score);
    check_eq("hi_score", int'(hi_score), m_hi);
    check_eq("timer", int'(timer), m_timer);
    check_eq("timer_running", int'(timer_running), int'(m_run));
    check_eq("sec_tick", int'(sec_tick), int'(m_tick));
    check_eq("cmd_ack", int'(cmd_if.cmd_ack), int'(m_ack));
    check_eq("cmd_err", int'(cmd_if.cmd_err), int'(m_err));
    check_eq("cmd_ready", int'(cmd_if.cmd_ready),
             int'(!(m_run && m_elapsed == SEC_CYC - 1 && m_timer <= 1)));
  endtask

  task automatic send(input int c);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd       = 3'(c);
    cycle();
    cmd_if.cmd_valid = 1'b0;
  endtask

  task automatic wait_state(input string tag, input int target, input int budget);
    int n;
    n = 0;
    while (int'(state) != target && n < budget) begin
      cycle();
      n++;
    end
    check_eq(tag, int'(state), target);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int n_tick, first_tick, t_hold, n;
    rst_n = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd = 3'd0;
    repeat (2) cycle();
    rst_n = 1'b1;
    check_eq("rst_state", int'(state), 0);
    check_eq("rst_lives", int'(lives), 3);
    check_eq("rst_ready", int'(cmd_if.cmd_ready), 1);

    // countdown into PLAY
    send(4);
    check_eq("arm_ack", int'(cmd_if.cmd_ack), 1);
    check_eq("arm_timer", int'(timer), 2);
    n_tick = 0; first_tick = -1;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (sec_tick) begin
        if (n_tick == 0) first_tick = i;
        n_tick++;
      end
    end
    check_eq("ready_to_play_state", int'(state), 1);
    check_eq("ready_to_play_timer", int'(timer), 6);
    check_eq("tick_count", n_tick, 2);
    check_eq("tick_first", first_tick, 19);

    // scoring and game over
    repeat (3) send(0);
    check_eq("score_30", int'(score), 30);
    repeat (3) send(1);
    check_eq("over_lives", int'(lives), 0);
    check_eq("over_state", int'(state), 3);
    check_eq("over_hi", int'(hi_score), 30);
    t_hold = int'(timer);
    repeat (30) cycle();
    check_eq("over_timer_frozen", int'(timer), t_hold);
    send(2);
    check_eq("pause_in_over_err", int'(cmd_if.cmd_err), 1);
    check_eq("pause_in_over_state", int'(state), 3);
    send(6);
    check_eq("restart_score", int'(score), 0);
    send(0);
    check_eq("add_in_ready_err", int'(cmd_if.cmd_err), 1);
    send(7);
    check_eq("rsvd_err", int'(cmd_if.cmd_err), 1);

    // stage 1 then stage 2 at the floor length
    send(4);
    wait_state("s1_play", 1, 60);
    check_eq("s1_timer", int'(timer), 6);
    wait_state("s1_clear", 4, 200);
    send(5);
    check_eq("s2_stage", int'(stage), 2);
    send(4);
    wait_state("s2_play", 1, 60);
    check_eq("s2_timer_floor", int'(timer), 3);
    wait_state("game_clear", 5, 100);
    check_eq("game_clear_hi", int'(hi_score), 30);

    // pause keeps the prescalers
    send(6);
    send(4);
    wait_state("p_play", 1, 60);
    repeat (6) cycle();
    send(2);
    check_eq("paused", int'(state), 2);
    t_hold = int'(timer);
    repeat (100) cycle();
    check_eq("pause_timer_held", int'(timer), t_hold);
    send(3);
    n = 0;
    do begin
      cycle();
      n++;
    end while (!sec_tick && n < 40);
    check_eq("resume_tick_delay", n, 13);
    repeat (3) send(1);
    send(6);

    // command held across the expiry wrap, then score saturation
    send(4);
    repeat (39) cycle();
    check_eq("expiry_ready_low", int'(cmd_if.cmd_ready), 0);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd = 3'd0;
    cycle();
    check_eq("expiry_state", int'(state), 1);
    check_eq("expiry_no_ack", int'(cmd_if.cmd_ack), 0);
    cycle();
    cmd_if.cmd_valid = 1'b0;
    check_eq("pending_ack", int'(cmd_if.cmd_ack), 1);
    check_eq("pending_score", int'(score), 10);
    cmd_if.cmd_valid = 1'b1;
    repeat (101) cycle();
    cmd_if.cmd_valid = 1'b0;
    check_eq("score_1020", int'(score), 1020);
    send(0);
    check_eq("score_sat", int'(score), 1023);
    send(0);
    check_eq("score_sat_hold", int'(score), 1023);
    repeat (5) cycle();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    check_eq("midplay_rst_state", int'(state), 0);
    check_eq("midplay_rst_hi", int'(hi_score), 0);
    check_eq("midplay_rst_score", int'(score), 0);
    check_eq("midplay_rst_running", int'(timer_running), 0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      cmd_if.cmd_valid = ($urandom_range(0, 2) == 0);
      cmd_if.cmd = 3'($urandom_range(0, 7));
      cycle();
    end
    rst_n = 1'b1;
    cmd_if.cmd_valid = 1'b0;
    cycle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
